pipe_control_unit: RTL and testbench

Second-generation control unit for the 5-stage MIPS pipeline. It decodes opcode and funct in ID, then carries the control bundle through internal ID/EX, EX/MEM and MEM/WB control registers, so each stage reads its own aligned control signals. It handles stall and flush bubbles, flags and counts illegal instructions, and widens the decoded instruction set with bne, jal, jr, andi, ori, slti and slt.

---
 rtl/pipe_control_unit.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_pipe_control_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit.sv
// ---------------------------------------------------------------------------
// pipe_control_unit
//
// Purpose:
//   Control unit for the 5-stage MIPS pipeline. It decodes opcode/funct in
//   ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB
//   control registers, so each stage sees its own aligned control.
//   It inserts bubbles for stall, flush and illegal instructions, pulses
//   illegal_op in EX and keeps a saturating count of illegal instructions.
//
// Optional feature (macro MULDIV_EN):
//   Makes mult/mfhi/mflo legal. It adds a multiplier busy down-counter of
//   MD_LAT cycles and an ex_HiLoSel output. While the multiplier is busy,
//   an mfhi/mflo in ID is turned into a bubble. Without the macro, md_busy
//   is tied to 0 and those functs decode as illegal.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_opcode, id_funct   instruction fields in ID
//   id_valid              ID holds a real instruction
//   stall, flush_ex       hazard stall / redirect; both load a bubble into EX
//   ex_*                  EX-stage control (ALU, operands, branch/jump)
//   mem_*                 MEM-stage control (store enable, forwarding info)
//   wb_*                  WB-stage control (write enable, result select, link)
//   illegal_op            one-cycle pulse aligned with the illegal bubble in EX
//   illegal_count         saturating illegal-instruction counter
//   ex_HiLoSel            (MULDIV_EN only) 1 = read hi, 0 = read lo
//   md_busy               multiplier busy
// ---------------------------------------------------------------------------
module pipe_control_unit #(
  parameter int ALUSEL_W = 4,
  parameter int CNT_W    = 8,
  parameter int MD_LAT   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          id_opcode,
  input  logic [5:0]          id_funct,
  input  logic                id_valid,
  input  logic                stall,
  input  logic                flush_ex,
  output logic [ALUSEL_W-1:0] ex_ALUSel,
  output logic                ex_ALUInSel,
  output logic                ex_ZeroExt,
  output logic [1:0]          ex_RFDSel,
  output logic                ex_Branch,
  output logic                ex_BranchNE,
  output logic                ex_Jump,
  output logic                ex_JumpReg,
  output logic                mem_DMWE,
  output logic                mem_MtoRFSel,
  output logic                mem_RFWE,
  output logic                wb_RFWE,
  output logic                wb_MtoRFSel,
  output logic                wb_Link,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    illegal_count,
`ifdef MULDIV_EN
  output logic                ex_HiLoSel,
`endif
  output logic                md_busy
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLLV = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_SRAV = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;

  // Decoded (not yet registered) control bundle for the ID instruction.
  logic [3:0] dec_alu;
  logic       dec_aluin, dec_zext;
  logic [1:0] dec_rfd;
  logic       dec_br, dec_bne, dec_jmp, dec_jr;
  logic       dec_dmwe, dec_mtorf, dec_rfwe, dec_link;
  logic       dec_legal;
`ifdef MULDIV_EN
  logic       dec_hilo, dec_mult, dec_mfx;
`endif

  // Control carried through EX and MEM for the later stages.
  logic ex_dmwe, ex_mtorf, ex_rfwe, ex_link;
  logic mem_link;

  // ID/EX load decision.
  logic take_bubble, is_illegal, issue;

  // Combinational decode. Everything defaults to 0 so unused fields and
  // illegal encodings never carry stray enables; dec_legal drops for any
  // opcode/funct outside the table.
  always_comb begin
    dec_alu   = ALU_ADD;
    dec_aluin = 1'b0;
    dec_zext  = 1'b0;
    dec_rfd   = 2'b00;
    dec_br    = 1'b0;
    dec_bne   = 1'b0;
    dec_jmp   = 1'b0;
    dec_jr    = 1'b0;
    dec_dmwe  = 1'b0;
    dec_mtorf = 1'b0;
    dec_rfwe  = 1'b0;
    dec_link  = 1'b0;
    dec_legal = 1'b1;
`ifdef MULDIV_EN
    dec_hilo  = 1'b0;
    dec_mult  = 1'b0;
    dec_mfx   = 1'b0;
`endif
    case (id_opcode)
      6'b000000: begin
        dec_rfwe = 1'b1;
        dec_rfd  = 2'b01;
        case (id_funct)
          6'b100000: dec_alu = ALU_ADD;
          6'b100010: dec_alu = ALU_SUB;
          6'b100100: dec_alu = ALU_AND;
          6'b100101: dec_alu = ALU_OR;
          6'b000000: dec_alu = ALU_SLL;
          6'b000100: dec_alu = ALU_SLLV;
          6'b000111: dec_alu = ALU_SRAV;
          6'b101010: dec_alu = ALU_SLT;
          6'b001000: begin
            dec_rfwe = 1'b0;
            dec_rfd  = 2'b00;
            dec_jr   = 1'b1;
          end
`ifdef MULDIV_EN
          6'b011000: begin
            dec_rfwe = 1'b0;
            dec_rfd  = 2'b00;
            dec_mult = 1'b1;
          end
          6'b010000: begin
            dec_mfx  = 1'b1;
            dec_hilo = 1'b1;
          end
          6'b010010: dec_mfx = 1'b1;
`endif
          default: begin
            dec_rfwe  = 1'b0;
            dec_rfd   = 2'b00;
            dec_legal = 1'b0;
          end
        endcase
      end
      6'b100011: begin
        dec_rfwe  = 1'b1;
        dec_aluin = 1'b1;
        dec_mtorf = 1'b1;
      end
      6'b101011: begin
        dec_dmwe  = 1'b1;
        dec_aluin = 1'b1;
      end
      6'b000100: begin
        dec_br  = 1'b1;
        dec_alu = ALU_SUB;
      end
      6'b000101: begin
        dec_bne = 1'b1;
        dec_alu = ALU_SUB;
      end
      6'b000010: dec_jmp = 1'b1;
      6'b000011: begin
        dec_jmp  = 1'b1;
        dec_rfwe = 1'b1;
        dec_rfd  = 2'b10;
        dec_link = 1'b1;
      end
      6'b001000: begin
        dec_rfwe  = 1'b1;
        dec_aluin = 1'b1;
      end
      6'b001100: begin
        dec_rfwe  = 1'b1;
        dec_aluin = 1'b1;
        dec_zext  = 1'b1;
        dec_alu   = ALU_AND;
      end
      6'b001101: begin
        dec_rfwe  = 1'b1;
        dec_aluin = 1'b1;
        dec_zext  = 1'b1;
        dec_alu   = ALU_OR;
      end
      6'b001010: begin
        dec_rfwe  = 1'b1;
        dec_aluin = 1'b1;
        dec_alu   = ALU_SLT;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Decide what enters EX. Stall/flush/empty ID win over illegal, so a
  // killed illegal instruction never pulses illegal_op. An mfhi/mflo that
  // would read hi/lo before the multiplier finishes is held back as a bubble.
  always_comb begin
    take_bubble = flush_ex | stall | ~id_valid;
    is_illegal  = ~take_bubble & ~dec_legal;
`ifdef MULDIV_EN
    issue       = ~take_bubble & dec_legal & ~(dec_mfx & md_busy);
`else
    issue       = ~take_bubble & dec_legal;
`endif
  end

  // ID/EX control register: loads the decoded bundle only when issuing,
  // otherwise all zeros (bubble).
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ALUSel   <= '0;
      ex_ALUInSel <= 1'b0;
      ex_ZeroExt  <= 1'b0;
      ex_RFDSel   <= 2'b00;
      ex_Branch   <= 1'b0;
      ex_BranchNE <= 1'b0;
      ex_Jump     <= 1'b0;
      ex_JumpReg  <= 1'b0;
      ex_dmwe     <= 1'b0;
      ex_mtorf    <= 1'b0;
      ex_rfwe     <= 1'b0;
      ex_link     <= 1'b0;
      illegal_op  <= 1'b0;
`ifdef MULDIV_EN
      ex_HiLoSel  <= 1'b0;
`endif
    end else begin
      ex_ALUSel   <= issue ? ALUSEL_W'(dec_alu) : '0;
      ex_ALUInSel <= issue & dec_aluin;
      ex_ZeroExt  <= issue & dec_zext;
      ex_RFDSel   <= issue ? dec_rfd : 2'b00;
      ex_Branch   <= issue & dec_br;
      ex_BranchNE <= issue & dec_bne;
      ex_Jump     <= issue & dec_jmp;
      ex_JumpReg  <= issue & dec_jr;
      ex_dmwe     <= issue & dec_dmwe;
      ex_mtorf    <= issue & dec_mtorf;
      ex_rfwe     <= issue & dec_rfwe;
      ex_link     <= issue & dec_link;
      illegal_op  <= is_illegal;
`ifdef MULDIV_EN
      ex_HiLoSel  <= issue & dec_hilo;
`endif
    end
  end

  // EX/MEM and MEM/WB control registers always advance; nothing downstream
  // of EX can hold the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_DMWE     <= 1'b0;
      mem_MtoRFSel <= 1'b0;
      mem_RFWE     <= 1'b0;
      mem_link     <= 1'b0;
      wb_RFWE      <= 1'b0;
      wb_MtoRFSel  <= 1'b0;
      wb_Link      <= 1'b0;
    end else begin
      mem_DMWE     <= ex_dmwe;
      mem_MtoRFSel <= ex_mtorf;
      mem_RFWE     <= ex_rfwe;
      mem_link     <= ex_link;
      wb_RFWE      <= mem_RFWE;
      wb_MtoRFSel  <= mem_MtoRFSel;
      wb_Link      <= mem_link;
    end
  end

  // Counts illegal_op pulses as they are seen in EX; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_count <= '0;
    end else if (illegal_op && (illegal_count != '1)) begin
      illegal_count <= illegal_count + 1'b1;
    end
  end

`ifdef MULDIV_EN
  localparam int MD_CW = (MD_LAT < 1) ? 1 : $clog2(MD_LAT + 1);

  logic [MD_CW-1:0] md_cnt;

  // Multiplier busy timer: a mult entering EX (re)loads MD_LAT, then it
  // counts down to zero; busy is simply "counter not yet zero".
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (issue && dec_mult) begin
      md_cnt <= MD_CW'(MD_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  assign md_busy = (md_cnt != '0);
`else
  assign md_busy = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_control_unit
//
// Purpose:
//   Self-checking bench for pipe_control_unit. A driver applies directed and
//   random instructions and, for every edge, pushes the expected output
//   snapshot from a behavioural model into a queue. A monitor pops one
//   snapshot per cycle and compares it with the DUT outputs.
//   It builds with or without MULDIV_EN.
// ---------------------------------------------------------------------------
module tb_pipe_control_unit;

  localparam int ALUSEL_W = 4;
  localparam int CNT_W    = 8;
  localparam int MD_LAT   = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [5:0]          id_opcode, id_funct;
  logic                id_valid, stall, flush_ex;
  logic [ALUSEL_W-1:0] ex_ALUSel;
  logic                ex_ALUInSel, ex_ZeroExt;
  logic [1:0]          ex_RFDSel;
  logic                ex_Branch, ex_BranchNE, ex_Jump, ex_JumpReg;
  logic                mem_DMWE, mem_MtoRFSel, mem_RFWE;
  logic                wb_RFWE, wb_MtoRFSel, wb_Link;
  logic                illegal_op;
  logic [CNT_W-1:0]    illegal_count;
  logic                md_busy;
  logic                hiLoSel;

  // Decoded meaning of one instruction, straight from the decode table.
  typedef struct packed {
    logic       legal;
    logic [3:0] alu;
    logic       aluIn, zext;
    logic [1:0] rfd;
    logic       br, bne, jmp, jr;
    logic       dmwe, mtorf, rfwe, link;
    logic       hilo, mult, mfx;
  } ctrlT;

  // Everything the DUT shows in one cycle.
  typedef struct packed {
    logic [3:0] exAlu;
    logic       exAluIn, exZext;
    logic [1:0] exRfd;
    logic       exBr, exBne, exJ, exJr, exHilo;
    logic       illegal;
    logic       memDmwe, memMtorf, memRfwe;
    logic       wbRfwe, wbMtorf, wbLink;
    logic [7:0] count;
    logic       busy;
  } snapT;

  snapT expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  // Model state: instruction control held in EX, MEM, WB (index 0..2).
  ctrlT stageM[3];
  logic illegalM;
  int   countM;
  int   busyLeftM;

  logic [5:0] randOps[12] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                              6'h03, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h3f};
  logic [5:0] randFns[12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h04,
                              6'h07, 6'h2a, 6'h08, 6'h18, 6'h10, 6'h12};

  pipe_control_unit #(
    .ALUSEL_W(ALUSEL_W),
    .CNT_W   (CNT_W),
    .MD_LAT  (MD_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_opcode    (id_opcode),
    .id_funct     (id_funct),
    .id_valid     (id_valid),
    .stall        (stall),
    .flush_ex     (flush_ex),
    .ex_ALUSel    (ex_ALUSel),
    .ex_ALUInSel  (ex_ALUInSel),
    .ex_ZeroExt   (ex_ZeroExt),
    .ex_RFDSel    (ex_RFDSel),
    .ex_Branch    (ex_Branch),
    .ex_BranchNE  (ex_BranchNE),
    .ex_Jump      (ex_Jump),
    .ex_JumpReg   (ex_JumpReg),
    .mem_DMWE     (mem_DMWE),
    .mem_MtoRFSel (mem_MtoRFSel),
    .mem_RFWE     (mem_RFWE),
    .wb_RFWE      (wb_RFWE),
    .wb_MtoRFSel  (wb_MtoRFSel),
    .wb_Link      (wb_Link),
    .illegal_op   (illegal_op),
    .illegal_count(illegal_count),
`ifdef MULDIV_EN
    .ex_HiLoSel   (hiLoSel),
`endif
    .md_busy      (md_busy)
  );

`ifndef MULDIV_EN
  assign hiLoSel = 1'b0;
`endif

  always #5 clk = ~clk;

  // Reference decode table for one instruction.
  function automatic ctrlT decodeRef(input logic [5:0] op, input logic [5:0] fn);
    ctrlT c;
    c = '0;
    c.legal = 1'b1;
    case (op)
      6'h00: begin
        c.rfwe = 1'b1;
        c.rfd  = 2'b01;
        case (fn)
          6'b100000: c.alu = 4'b0000;
          6'b100010: c.alu = 4'b0001;
          6'b100100: c.alu = 4'b0101;
          6'b100101: c.alu = 4'b1001;
          6'b000000: c.alu = 4'b0010;
          6'b000100: c.alu = 4'b0100;
          6'b000111: c.alu = 4'b0111;
          6'b101010: c.alu = 4'b1010;
          6'b001000: begin c.rfwe = 1'b0; c.rfd = 2'b00; c.jr = 1'b1; end
`ifdef MULDIV_EN
          6'b011000: begin c.rfwe = 1'b0; c.rfd = 2'b00; c.mult = 1'b1; end
          6'b010000: begin c.mfx = 1'b1; c.hilo = 1'b1; end
          6'b010010: c.mfx = 1'b1;
`endif
          default: c = '0;
        endcase
      end
      6'h23: begin c.rfwe = 1'b1; c.aluIn = 1'b1; c.mtorf = 1'b1; end
      6'h2b: begin c.dmwe = 1'b1; c.aluIn = 1'b1; end
      6'h04: begin c.br = 1'b1; c.alu = 4'b0001; end
      6'h05: begin c.bne = 1'b1; c.alu = 4'b0001; end
      6'h02: c.jmp = 1'b1;
      6'h03: begin c.jmp = 1'b1; c.rfwe = 1'b1; c.rfd = 2'b10; c.link = 1'b1; end
      6'h08: begin c.rfwe = 1'b1; c.aluIn = 1'b1; end
      6'h0c: begin c.rfwe = 1'b1; c.aluIn = 1'b1; c.zext = 1'b1; c.alu = 4'b0101; end
      6'h0d: begin c.rfwe = 1'b1; c.aluIn = 1'b1; c.zext = 1'b1; c.alu = 4'b1001; end
      6'h0a: begin c.rfwe = 1'b1; c.aluIn = 1'b1; c.alu = 4'b1010; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Drive one cycle of inputs, advance the model across the coming edge,
  // queue the expected outputs, then move to just after that edge.
  task automatic applyStimulus(input logic rst, input logic vld,
                               input logic [5:0] op, input logic [5:0] fn,
                               input logic stl, input logic fl);
    ctrlT d, loadC;
    logic ill;
    int   nextCount;
    snapT s;
    reset     = rst;
    id_valid  = vld;
    id_opcode = op;
    id_funct  = fn;
    stall     = stl;
    flush_ex  = fl;
    d     = decodeRef(op, fn);
    loadC = '0;
    ill   = 1'b0;
    if (rst) begin
      for (int i = 0; i < 3; i++) stageM[i] = '0;
      illegalM  = 1'b0;
      countM    = 0;
      busyLeftM = 0;
    end else begin
      nextCount = (illegalM && countM < 255) ? countM + 1 : countM;
      if (!(fl || stl || !vld)) begin
        if (!d.legal) ill = 1'b1;
        else if (!(d.mfx && busyLeftM > 0)) loadC = d;
      end
      if (loadC.mult) busyLeftM = MD_LAT;
      else if (busyLeftM > 0) busyLeftM = busyLeftM - 1;
      stageM[2] = stageM[1];
      stageM[1] = stageM[0];
      stageM[0] = loadC;
      illegalM  = ill;
      countM    = nextCount;
    end
    s.exAlu    = stageM[0].alu;
    s.exAluIn  = stageM[0].aluIn;
    s.exZext   = stageM[0].zext;
    s.exRfd    = stageM[0].rfd;
    s.exBr     = stageM[0].br;
    s.exBne    = stageM[0].bne;
    s.exJ      = stageM[0].jmp;
    s.exJr     = stageM[0].jr;
    s.exHilo   = stageM[0].hilo;
    s.illegal  = illegalM;
    s.memDmwe  = stageM[1].dmwe;
    s.memMtorf = stageM[1].mtorf;
    s.memRfwe  = stageM[1].rfwe;
    s.wbRfwe   = stageM[2].rfwe;
    s.wbMtorf  = stageM[2].mtorf;
    s.wbLink   = stageM[2].link;
    s.count    = 8'(countM);
    s.busy     = (busyLeftM > 0);
    expQ.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                  name, $time, act, exp);
  endtask

  // Monitor: one snapshot per cycle, sampled on the falling edge.
  initial begin
    snapT e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("ex_bundle",
                    {19'd0, ex_ALUSel, ex_ALUInSel, ex_ZeroExt, ex_RFDSel,
                     ex_Branch, ex_BranchNE, ex_Jump, ex_JumpReg, hiLoSel},
                    {19'd0, e.exAlu, e.exAluIn, e.exZext, e.exRfd,
                     e.exBr, e.exBne, e.exJ, e.exJr, e.exHilo});
        checkOutput("illegal_op", {31'd0, illegal_op}, {31'd0, e.illegal});
        checkOutput("mem_bundle", {29'd0, mem_DMWE, mem_MtoRFSel, mem_RFWE},
                    {29'd0, e.memDmwe, e.memMtorf, e.memRfwe});
        checkOutput("wb_bundle", {29'd0, wb_RFWE, wb_MtoRFSel, wb_Link},
                    {29'd0, e.wbRfwe, e.wbMtorf, e.wbLink});
        checkOutput("illegal_count", {24'd0, illegal_count}, {24'd0, e.count});
        checkOutput("md_busy", {31'd0, md_busy}, {31'd0, e.busy});
      end
    end
  end

  initial begin
    logic [5:0] op, fn;
    // reset held two cycles while a valid lw sits in ID, then let it go
    applyStimulus(1, 1, 6'h23, 6'h00, 0, 0);
    applyStimulus(1, 1, 6'h23, 6'h00, 0, 0);
    applyStimulus(0, 1, 6'h23, 6'h00, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 6'h00, 6'h00, 0, 0);
    // add, sw, jal back to back
    applyStimulus(0, 1, 6'h00, 6'h20, 0, 0);
    applyStimulus(0, 1, 6'h2b, 6'h00, 0, 0);
    applyStimulus(0, 1, 6'h03, 6'h00, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 6'h00, 6'h00, 0, 0);
    // beq stalled one cycle, then beq flushed
    applyStimulus(0, 1, 6'h04, 6'h00, 1, 0);
    applyStimulus(0, 1, 6'h04, 6'h00, 0, 0);
    applyStimulus(0, 1, 6'h04, 6'h00, 0, 1);
    // slt, jr, andi, ori, slti, bne, j
    applyStimulus(0, 1, 6'h00, 6'h2a, 0, 0);
    applyStimulus(0, 1, 6'h00, 6'h08, 0, 0);
    applyStimulus(0, 1, 6'h0c, 6'h00, 0, 0);
    applyStimulus(0, 1, 6'h0d, 6'h00, 0, 0);
    applyStimulus(0, 1, 6'h0a, 6'h00, 0, 0);
    applyStimulus(0, 1, 6'h05, 6'h00, 0, 0);
    applyStimulus(0, 1, 6'h02, 6'h00, 0, 0);
    // illegal under simultaneous stall+flush, then a bare illegal funct
    applyStimulus(0, 1, 6'h3f, 6'h00, 1, 1);
    applyStimulus(0, 1, 6'h00, 6'h3f, 0, 0);
    // reset in the middle of in-flight instructions
    applyStimulus(0, 1, 6'h23, 6'h00, 0, 0);
    applyStimulus(0, 1, 6'h00, 6'h20, 0, 0);
    applyStimulus(1, 1, 6'h03, 6'h00, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 6'h00, 6'h00, 0, 0);
    // 300 cycles of an illegal opcode: counter must saturate at 255
    for (int i = 0; i < 300; i++) applyStimulus(0, 1, 6'h3f, 6'h00, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 6'h00, 6'h00, 0, 0);
    // mult followed by mflo held in ID
    applyStimulus(0, 1, 6'h00, 6'h18, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 6'h00, 6'h12, 0, 0);
    applyStimulus(0, 1, 6'h00, 6'h18, 0, 0);
    applyStimulus(0, 1, 6'h00, 6'h10, 0, 0);
    applyStimulus(0, 1, 6'h00, 6'h18, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 6'h00, 6'h10, 0, 0);
    // random traffic
    for (int i = 0; i < 500; i++) begin
      op = randOps[$urandom_range(0, 11)];
      fn = randFns[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom_range(0, 63));
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                    op, fn, ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0));
    end
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
